// File: rtl/key_pkg.sv
// key_pkg: shared definitions for the push-button conditioning front end.
//   CLK_HZ                  system clock frequency
//   DEBOUNCE_CYCLES_DEFAULT stable samples needed to commit a change (10 ms)
//   key_state_e             per-channel debounce FSM state encoding
package key_pkg;

   localparam int unsigned CLK_HZ = 50_000_000;
   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = CLK_HZ / 100;

   typedef enum logic [1:0] {
      StIdle        = 2'd0,
      StPressWait   = 2'd1,
      StPressed     = 2'd2,
      StReleaseWait = 2'd3
   } key_state_e;

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one push-button channel. Synchronizes the raw active-low key,
// debounces it with a counter FSM and produces registered level/press/release/toggle.
//   clk          system clock
//   reset        asynchronous active-high reset
//   key_n        raw button, active-low, asynchronous to clk
//   key_level    debounced state, 1 = pressed
//   key_press    one-cycle pulse on committed press
//   key_release  one-cycle pulse on committed release
//   key_toggle   inverts on every committed press
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic key_level,
   output logic key_press,
   output logic key_release,
   output logic key_toggle
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("key_debounce_ch: DEBOUNCE_CYCLES must be >= 2");
   end

   logic             r_sync1, r_sync2;
   key_state_e       r_state, w_state_d;
   logic [CNT_W-1:0] r_cnt, w_cnt_d;
   logic             r_level, w_level_d;
   logic             r_press, w_press_d;
   logic             r_release, w_release_d;
   logic             r_toggle, w_toggle_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_state   <= StIdle;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_toggle  <= 1'b0;
      end else begin
         // Invert here so the synchronized value reads 1 = pressed.
         r_sync1   <= ~key_n;
         r_sync2   <= r_sync1;
         r_state   <= w_state_d;
         r_cnt     <= w_cnt_d;
         r_level   <= w_level_d;
         r_press   <= w_press_d;
         r_release <= w_release_d;
         r_toggle  <= w_toggle_d;
      end
   end

   always_comb begin
      w_state_d   = r_state;
      w_cnt_d     = r_cnt;
      w_level_d   = r_level;
      w_press_d   = 1'b0;
      w_release_d = 1'b0;
      w_toggle_d  = r_toggle;
      unique case (r_state)
         StIdle: begin
            if (r_sync2) begin
               w_state_d = StPressWait;
               w_cnt_d   = CNT_ONE;
            end
         end
         StPressWait: begin
            if (!r_sync2) begin
               // Bounce: abandon the wait silently.
               w_state_d = StIdle;
               w_cnt_d   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_d  = StPressed;
               w_cnt_d    = '0;
               w_level_d  = 1'b1;
               w_press_d  = 1'b1;
               w_toggle_d = ~r_toggle;
            end else begin
               w_cnt_d = r_cnt + CNT_ONE;
            end
         end
         StPressed: begin
            if (!r_sync2) begin
               w_state_d = StReleaseWait;
               w_cnt_d   = CNT_ONE;
            end
         end
         StReleaseWait: begin
            if (r_sync2) begin
               w_state_d = StPressed;
               w_cnt_d   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_d   = StIdle;
               w_cnt_d     = '0;
               w_level_d   = 1'b0;
               w_release_d = 1'b1;
            end else begin
               w_cnt_d = r_cnt + CNT_ONE;
            end
         end
         default: begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
         end
      endcase
   end

   assign key_level   = r_level;
   assign key_press   = r_press;
   assign key_release = r_release;
   assign key_toggle  = r_toggle;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: push-button front end for the display logic. One independent
// debounce channel per key.
//   clk          system clock (single domain)
//   reset        asynchronous active-high reset
//   key_n        raw buttons, active-low
//   key_level    debounced levels, 1 = pressed
//   key_press    one-cycle press pulses
//   key_release  one-cycle release pulses
//   key_toggle   press-toggled state per key
module key_conditioner
   import key_pkg::*;
#(
   parameter int unsigned NUM_KEYS        = 2,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_toggle
);

   if (NUM_KEYS < 1) begin : g_bad_num_keys
      $error("key_conditioner: NUM_KEYS must be >= 1");
   end

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
      key_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
         .clk         (clk),
         .reset       (reset),
         .key_n       (key_n[g]),
         .key_level   (key_level[g]),
         .key_press   (key_press[g]),
         .key_release (key_release[g]),
         .key_toggle  (key_toggle[g])
      );
   end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Front-end conditioning stage for the board push-buttons, placed directly upstream of the LED/seven-segment display logic. It synchronizes the raw active-low `key_n` inputs into the clock domain and debounces each one with a counter-based state machine. For each key it produces a clean active-high level, one-cycle press and release pulses, and a press-toggled state. The display logic uses the level for the LED invert and the toggle for the date select on HEX2.

## Interface
- `NUM_KEYS`, default 2: number of push-button channels.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable samples needed to commit a change (10 ms at 50 MHz). Must be ≥2; out-of-range values are an elaboration error.
- `clk`  input  1: system clock. One clock domain only.
- `reset`  input  1: asynchronous, active-high reset.
- `key_n`  input  NUM_KEYS: raw buttons, active-low (0 = pressed), asynchronous to `clk`.
- `key_level`  output  NUM_KEYS: debounced state, 1 = pressed.
- `key_press`  output  NUM_KEYS: one-cycle pulse on the committed press.
- `key_release`  output  NUM_KEYS: one-cycle pulse on the committed release.
- `key_toggle`  output  NUM_KEYS: inverts on every committed press.

## Operation
- **Synchronizer.** Each channel passes `~key_n` through a 2-flop synchronizer, giving `sync = 1` for pressed. Synchronizer flops reset to 0 (released).
- **Per-channel FSM.** States are IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. The counter `cnt` is `$clog2(DEBOUNCE_CYCLES+1)` bits.
- **IDLE**
  - `sync = 1`: go to PRESS_WAIT, `cnt <= 1`.
  - Otherwise: stay.
- **PRESS_WAIT**
  - `sync = 0`: go to IDLE, `cnt <= 0`. Any bounce aborts the wait with no output change.
  - `sync = 1` and `cnt == DEBOUNCE_CYCLES-1`: go to PRESSED, `cnt <= 0`, `key_level <= 1`, `key_press <= 1`, `key_toggle <= ~key_toggle`.
  - Otherwise: `cnt <= cnt+1`.
- **PRESSED**: the mirror of IDLE. `sync = 0` goes to RELEASE_WAIT with `cnt <= 1`.
- **RELEASE_WAIT**: the mirror of PRESS_WAIT.
  - Bounce (`sync = 1`) returns to PRESSED.
  - On commit: go to IDLE, `key_level <= 0`, `key_release <= 1`.
- **Pulses.** `key_press` and `key_release` are registered and held for exactly one cycle; both default to 0 on every other cycle.
- **Channel independence.** Channels are fully independent. Simultaneous commits on several channels all pulse in the same cycle.
- **Reset values.** All outputs 0, all FSMs in IDLE, all counters 0.
- **Reset mid-operation.** Asserting reset during any WAIT state discards the partial count. Asserting reset while PRESSED forces `key_level` to 0 and does not generate `key_release`.
- **Held key at reset release.** If a key is held down when reset deasserts, the block debounces it as a fresh press: it produces a `key_press` and flips `key_toggle`.

## Timing
- **Commit latency.** Counting the first rising edge that samples the raw key low as edge 1, `key_level` and `key_press` are updated on edge `DEBOUNCE_CYCLES+2`. The release path has identical latency.
- **Minimum accepted pulse.** A raw pulse shorter than `DEBOUNCE_CYCLES` cycles (after synchronization) produces no output activity.
- **Pulse spacing.** `key_press` and `key_release` on the same channel are separated by at least `DEBOUNCE_CYCLES` cycles.
- **No combinational paths.** There is no combinational path from `key_n` to any output; all outputs are registered.

## Structure
- Shared package `key_pkg` holds:
  - the state encoding typedef (IDLE=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3);
  - the default `DEBOUNCE_CYCLES` constant;
  - the `CLK_HZ` constant (50_000_000).
- The natural sub-module is `key_debounce_ch`: one channel containing the synchronizer, FSM, counter and the four outputs.
- The top level instantiates `NUM_KEYS` copies of `key_debounce_ch` in a generate loop.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4` and `NUM_KEYS = 2`.
- **Reset state.** Assert reset with `key_n = 2'b11`, then deassert. Required: all outputs 0 and held 0 for 20 cycles.
- **Clean press.** Drive `key_n[0] = 0` at edge 1 and hold. Required:
  - `key_level[0] = 1` and `key_press[0] = 1` after edge 6;
  - `key_press[0]` back to 0 after edge 7;
  - `key_toggle[0] = 1`;
  - channel 1 unchanged.
- **Bounce rejection.** Toggle `key_n[0]` every 2 cycles for 20 cycles, then hold it high. Required: no pulses and `key_level[0]` stays 0.
- **Release and toggle.** Do two full press/release pairs on key 1 with 10-cycle holds. Required:
  - `key_press[1]` pulses twice and `key_release[1]` pulses twice;
  - `key_toggle[1]` sequence is 0 → 1 → 0.
- **Simultaneous commit.** Drive both keys low on the same edge. Required: both `key_press` bits pulse in the same cycle, `key_press = 2'b11`.
- **Reset mid-operation.** Assert async reset mid-cycle while key 0 is PRESSED. Required:
  - `key_level[0]` goes to 0 immediately, without waiting for a clock edge;
  - no `key_release` pulse;
  - if the key is still held after reset deasserts, a fresh `key_press` follows 6 edges later.
